// File: rtl/sar_pkg.sv
// Shared definitions for the 16-bit successive-approximation controller:
// FSM state encoding and default geometry.
package sar_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SET    = 3'd1,
        S_WAIT   = 3'd2,
        S_DECIDE = 3'd3,
        S_FINISH = 3'd4
    } sar_state_t;

    localparam int SAR_WIDTH  = 16;
    localparam int SAR_SETTLE = 1;

endpackage

// File: rtl/sar_settle_cnt.sv
// Settle-time down-counter: loaded while the trial word is first applied,
// counts down through the WAIT cycles and flags when the last one is reached.
module sar_settle_cnt #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    // Loading SETTLE-1 makes the counter hit zero on the SETTLE-th WAIT cycle.
    localparam logic [3:0] LOAD_VAL = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    logic [3:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_expired = (r_cnt == 4'd0);

endmodule

// File: rtl/sar_ctrl_16.sv
// Successive-approximation register controller: walks the trial word MSB to
// LSB, keeping each bit the comparator reports as not exceeding the sample.
module sar_ctrl_16
    import sar_pkg::*;
#(
    parameter int WIDTH  = SAR_WIDTH,
    parameter int SETTLE = SAR_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sar_state_t       r_state, w_next;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] w_onehot;
    logic [WIDTH-1:0] w_work_dec;
    logic             w_expired;
    logic             w_begin;

    sar_settle_cnt #(.SETTLE(SETTLE)) u_settle (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == S_SET),
        .i_en      (r_state == S_WAIT),
        .o_expired (w_expired)
    );

    assign w_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << r_bit;
    assign w_work_dec = (r_work & ~w_onehot) | (cmp_in ? w_onehot : '0);
    assign w_begin    = (r_state == S_IDLE) && start && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort overrides every transition, including a start seen in IDLE.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_next = S_SET;
                S_SET:    w_next = (SETTLE == 0) ? S_DECIDE : S_WAIT;
                S_WAIT:   if (w_expired) w_next = S_DECIDE;
                S_DECIDE: w_next = (r_bit == '0) ? S_FINISH : S_SET;
                S_FINISH: w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_work   <= '0;
            r_bit    <= '0;
            r_result <= '0;
        end else if (w_begin) begin
            r_work <= '0;
            r_bit  <= BW'(WIDTH - 1);
        end else if ((r_state == S_DECIDE) && !abort) begin
            r_work <= w_work_dec;
            if (r_bit == '0) begin
                r_result <= w_work_dec;
            end else begin
                r_bit <= r_bit - BW'(1);
            end
        end
    end

    // The trial word stays on the DAC through DECIDE so the comparator is stable when sampled.
    always_comb begin
        trial = '0;
        if ((r_state == S_SET) || (r_state == S_WAIT) || (r_state == S_DECIDE)) begin
            trial = r_work | w_onehot;
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_FINISH);
    assign result = r_result;

endmodule
